// File: rtl/mux_pkg.sv
// Shared definitions for the N-input registered selector.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;  // explicit channel select
    localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

    // Index width for an n-entry channel set; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority request picker: first request after ptr, wrapping modulo N.
// Latency: purely combinational, no state (the pointer lives in the caller).
// Backpressure: none; the caller qualifies the grant with its own accept condition.
//
// Ports:
//   req     N     request vector
//   ptr     SELW  last granted index; search begins at ptr+1
//   gnt     N     one-hot grant (all zero when no request)
//   gnt_idx SELW  binary index of the grant
//   any     1     at least one request present
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N = 16,
    localparam int SELW = idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    int              idx;
    logic [SELW-1:0] idx_s;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_s   = '0;
        // ptr < N always, so ptr+k < 2N and a single subtraction wraps it.
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = SELW'(idx);
            if (!any && req[idx_s]) begin
                any        = 1'b1;
                gnt_idx    = idx_s;
                gnt[idx_s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input WIDTH-bit registered selector, explicit select or round-robin, with handshakes.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready follows out_ready combinationally; with MUX_ARB_SKID_EN a
//   one-entry skid absorbs one word and in_ready comes only from registered state.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_data  N*WIDTH    channel i at [i*WIDTH +: WIDTH]
//   in_valid/in_ready   per-channel handshake, at most one ready bit set
//   mode, sel           0 = use sel, 1 = round-robin
//   out_data/out_sel    registered word and the index that supplied it
//   out_valid/out_ready output handshake
// Optional feature macro: MUX_ARB_SKID_EN
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 16,
    localparam int SELW = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [WIDTH-1:0] in_words [N];
    logic             sel_hit;
    logic [N-1:0]     sel_gnt;
    logic             g_any;
    logic [SELW-1:0]  g_idx;
    logic             can_accept;
    logic             in_xfer;

    rr_arbiter_n #(.N(N)) u_rr (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_words[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        // Out-of-range selects (possible when N is not a power of two) never grant.
        sel_hit = (int'(sel) < N) && in_valid[sel];
        sel_gnt = '0;
        for (int i = 0; i < N; i++) begin
            sel_gnt[i] = sel_hit && (sel == SELW'(i));
        end
        if (mode == MODE_RR) begin
            g_any = rr_any;
            g_idx = rr_idx;
        end else begin
            g_any = sel_hit;
            g_idx = sel;
        end
        in_xfer  = g_any && can_accept && !rst;
        in_ready = ((mode == MODE_RR) ? rr_gnt : sel_gnt) & {N{can_accept && !rst}};
    end

`ifdef MUX_ARB_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_sel;

    assign can_accept = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else if (!out_valid || out_ready) begin
            // Output register is free this cycle; the skid word is older, so it goes first.
            // in_xfer cannot be true while skid_valid is set.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_sel    <= skid_sel;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_data  <= in_words[g_idx];
                out_sel   <= g_idx;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data  <= in_words[g_idx];
            skid_sel   <= g_idx;
            skid_valid <= 1'b1;
        end
    end
`else
    assign can_accept = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (in_xfer) begin
            out_data  <= in_words[g_idx];
            out_sel   <= g_idx;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    // Reset to N-1 so the first round-robin search starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SELW'(N - 1);
        end else if (in_xfer && (mode == MODE_RR)) begin
            ptr <= g_idx;
        end
    end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input, WIDTH-bit registered selector with per-input valid/ready handshake. It selects one source per cycle, either by an explicit select or by round-robin arbitration, and registers the chosen word with its source index. It sits between the ALU functional units and the writeback/result path. It replaces the fixed 16×32 combinational selector wherever results arrive on independent, back-pressured channels.

## Interface
- WIDTH, 32, data width of each input and of the output
- N, 16, number of input channels (2..64; need not be a power of two)
- SELW (localparam), $clog2(N), width of select and source-index fields

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit set per cycle
- mode  input  1  0 = explicit select, 1 = round-robin
- sel  input  SELW  channel index used when mode = 0
- out_data  output  WIDTH  selected word (registered)
- out_sel  output  SELW  index of channel that supplied out_data
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts output

## Operation
- Output register (OR) holds one word plus index and valid.
- can_accept = !out_valid || out_ready (without skid), per Configuration.
- Grant, mode 0: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants.
- Grant, mode 1: grant = first i with in_valid[i], searching ptr+1, ptr+2, … wrapping modulo N. No valid input means no grant.
- in_ready[g] = can_accept for the granted g; all other in_ready bits are 0.
- Input transfer: in_valid[g] && in_ready[g]. On transfer, OR <= {in_data[g], g}, and out_valid = 1.
- Output transfer: out_valid && out_ready. If no input transfer happens in the same cycle, out_valid <= 0.
- Simultaneous input and output transfer: OR is replaced in that cycle, with no bubble.
- ptr updates to g only on a mode-1 input transfer. Mode-0 transfers leave ptr unchanged.
- A mode change takes effect combinationally on the next grant. ptr is retained across the change.
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1 (so the first RR search starts at channel 0), skid empty.
- Reset mid-transfer drops any held word. No transfer completes in the reset cycle, and in_ready = 0 while rst = 1.

## Timing
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 word/cycle while out_ready = 1.
- Without skid, in_ready depends combinationally on out_ready, in_valid, mode and sel.
- out_data and out_sel are stable while out_valid && !out_ready.
- RR fairness: with all N inputs continuously valid, each channel is granted exactly once per N transfers.

## Configuration
- MUX_ARB_SKID_EN defined:
  - Adds a one-entry skid register behind OR.
  - can_accept = !skid_valid (registered); in_ready has no combinational path from out_ready.
  - A word accepted while OR is stalled lands in skid. skid drains into OR on the next output transfer.
  - in_ready deasserts the cycle after skid fills.
  - Ordering is preserved; latency is still 1 cycle when not stalled.
- Undefined: single OR only; behaviour as in Operation.

## Structure
- Package mux_pkg:
  - MODE_SEL = 1'b0, MODE_RR = 1'b1.
  - Function idx_w(N) returning $clog2(N) with a minimum of 1.
- Sub-module rr_arbiter_n (parameter N):
  - Inputs req[N] and ptr.
  - Outputs one-hot gnt, gnt_idx and any.
  - Purely combinational rotating-priority search; ptr storage stays in mux_arb_n.

## Test plan
- Mode 0, sel = 5, in_valid = 16'h0020, in_data[5] = 32'hDEADBEEF, out_ready = 1:
  - in_ready = 16'h0020 in cycle 0.
  - Cycle 1: out_valid = 1, out_data = DEADBEEF, out_sel = 5.
- Mode 0, sel = 3, in_valid[3] = 0, other inputs valid: in_ready = 0 and out_valid stays 0.
  - With N = 12, sel = 13 also yields no grant.
- Mode 1, all 16 inputs valid, out_ready = 1, in_data[i] = i: out_sel sequence is 0,1,…,15,0 on consecutive cycles.
- Mode 1, in_valid = 16'h8001, ptr = 0: grants 15, then 0, then 15.
  - Switching to mode 0 with sel = 0 grants 0 and leaves ptr = 15.
- Backpressure: stream 3 words, out_ready = 0 for 4 cycles, then 1.
  - out_data holds word 0 throughout the stall.
  - Without skid: in_ready = 0 during the stall.
  - With MUX_ARB_SKID_EN: word 1 is absorbed, then in_ready = 0.
  - No loss or reorder; words emerge as 0,1,2.
- Assert rst for 1 cycle while out_valid = 1 and stalled:
  - Next cycle out_valid = 0, out_data = 0, out_sel = 0.
  - The following RR grant with all inputs valid is channel 0.
